// File: rtl/quad_decoder.sv
// Quadrature (x4) decoder: 2-flop synchronizers, per-channel glitch filters,
// transition decode into a wrapping position counter with a sticky error flag.
module quad_decoder #(
  parameter int WIDTH = 8,
  parameter int FILT  = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             dir,
  output logic             wrap,
  output logic             err
);

  localparam logic [3:0]       FILT_LAST = 4'(FILT - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  typedef enum logic [1:0] {MV_NONE, MV_UP, MV_DN, MV_ILL} move_e;

  logic             a_m_q, a_s_q, b_m_q, b_s_q;
  logic             a_f_q, a_f_d, b_f_q, b_f_d;
  logic [3:0]       a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic             pa_q, pb_q;
  logic [WIDTH-1:0] count_q, count_d;
  logic             step_q, step_d, dir_q, dir_d, wrap_q, wrap_d, err_q, err_d;
  move_e            move;

  // A filtered level changes only after FILT consecutive disagreeing samples.
  always_comb begin
    a_f_d   = a_f_q;
    a_cnt_d = a_cnt_q;
    if (a_s_q == a_f_q) begin
      a_cnt_d = '0;
    end else if (a_cnt_q == FILT_LAST) begin
      a_f_d   = a_s_q;
      a_cnt_d = '0;
    end else begin
      a_cnt_d = a_cnt_q + 4'd1;
    end
  end

  always_comb begin
    b_f_d   = b_f_q;
    b_cnt_d = b_cnt_q;
    if (b_s_q == b_f_q) begin
      b_cnt_d = '0;
    end else if (b_cnt_q == FILT_LAST) begin
      b_f_d   = b_s_q;
      b_cnt_d = '0;
    end else begin
      b_cnt_d = b_cnt_q + 4'd1;
    end
  end

  // Index is {old A, old B, new A, new B}.
  always_comb begin
    move = MV_NONE;
    case ({pa_q, pb_q, a_f_q, b_f_q})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: move = MV_UP;
      4'b1000, 4'b1110, 4'b0111, 4'b0001: move = MV_DN;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: move = MV_ILL;
      default:                            move = MV_NONE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    err_d   = err_clr ? 1'b0 : err_q;
    case (move)
      MV_UP: begin
        step_d  = 1'b1;
        dir_d   = 1'b1;
        count_d = count_q + ONE;
        wrap_d  = &count_q;
      end
      MV_DN: begin
        step_d  = 1'b1;
        dir_d   = 1'b0;
        count_d = count_q - ONE;
        wrap_d  = ~|count_q;
      end
      MV_ILL:  err_d = 1'b1;
      default: ;
    endcase
    // Load overrides the count update only; step/dir still report the decode.
    if (load) begin
      count_d = din;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      a_m_q   <= 1'b0;
      a_s_q   <= 1'b0;
      b_m_q   <= 1'b0;
      b_s_q   <= 1'b0;
      a_f_q   <= 1'b0;
      b_f_q   <= 1'b0;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      pa_q    <= 1'b0;
      pb_q    <= 1'b0;
      count_q <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      a_m_q   <= a;
      a_s_q   <= a_m_q;
      b_m_q   <= b;
      b_s_q   <= b_m_q;
      a_f_q   <= a_f_d;
      b_f_q   <= b_f_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      pa_q    <= a_f_q;
      pb_q    <= b_f_q;
      count_q <= count_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign step  = step_q;
  assign dir   = dir_q;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (WIDTH=8, FILT=2): step latency, direction,
// wrap, glitch rejection, illegal transitions, load priority and reset.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       a = 1'b0, b = 1'b0;
  logic       load = 1'b0;
  logic [7:0] din = 8'd0;
  logic       err_clr = 1'b0;
  logic [7:0] count;
  logic       step, dir, wrap, err;

  int n_tests = 0;
  int n_fail  = 0;

  quad_decoder #(.WIDTH(8), .FILT(2)) dut (
    .clk(clk), .clr(clr), .a(a), .b(b), .load(load), .din(din),
    .err_clr(err_clr), .count(count), .step(step), .dir(dir),
    .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  // Change the pins just after an edge and watch 10 edges. Edge index 1 is
  // the first edge that samples the new value, so a step is due at index 5.
  task automatic move_pins(input logic na, input logic nb,
                           output int first, output int nsteps, output int wrap_at);
    first = -1; nsteps = 0; wrap_at = -1;
    @(posedge clk); #1;
    a = na; b = nb;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (step) begin
        nsteps++;
        if (first < 0) first = i;
      end
      if (wrap && wrap_at < 0) wrap_at = i;
    end
  endtask

  task automatic test_reset();
    a = 1'b0; b = 1'b0; clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({count, step, dir, wrap, err} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got count=%0d step=%b dir=%b wrap=%b err=%b, want all 0",
               count, step, dir, wrap, err);
    end
    clr = 1'b0;
  endtask

  task automatic test_forward();
    logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    int first, ns, wa;
    for (int k = 0; k < 4; k++) begin
      move_pins(seq[k][1], seq[k][0], first, ns, wa);
      n_tests++;
      if (first !== 5 || ns !== 1) begin
        n_fail++;
        $display("FAIL fwd_step_%0d: got first=%0d nsteps=%0d, want first=5 nsteps=1", k, first, ns);
      end
    end
    n_tests++;
    if (count !== 8'd4 || dir !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_final: got count=%0d dir=%b, want count=4 dir=1", count, dir);
    end
  endtask

  task automatic test_reverse_wrap();
    logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    int first, ns, wa;
    for (int k = 0; k < 4; k++) begin
      move_pins(seq[k][1], seq[k][0], first, ns, wa);
      n_tests++;
      if (first !== 5 || ns !== 1 || dir !== 1'b0) begin
        n_fail++;
        $display("FAIL rev_step_%0d: got first=%0d nsteps=%0d dir=%b, want 5 1 0", k, first, ns, dir);
      end
    end
    n_tests++;
    if (count !== 8'd0) begin
      n_fail++;
      $display("FAIL rev_final: got count=%0d, want 0", count);
    end
    move_pins(1'b0, 1'b1, first, ns, wa);
    n_tests++;
    if (count !== 8'd255 || wa !== 5 || ns !== 1 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL down_wrap: got count=%0d wrap_at=%0d nsteps=%0d wrap_now=%b, want 255 5 1 0",
               count, wa, ns, wrap);
    end
    move_pins(1'b0, 1'b0, first, ns, wa);
    n_tests++;
    if (count !== 8'd0 || wa !== 5 || dir !== 1'b1) begin
      n_fail++;
      $display("FAIL up_wrap: got count=%0d wrap_at=%0d dir=%b, want 0 5 1", count, wa, dir);
    end
  endtask

  task automatic test_glitch();
    int ups, downs;
    @(posedge clk); #1;
    a = 1'b1;
    @(posedge clk); #1;
    a = 1'b0;
    ups = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (step) ups++;
    end
    n_tests++;
    if (ups !== 0 || count !== 8'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_short: got steps=%0d count=%0d err=%b, want 0 0 0", ups, count, err);
    end
    ups = 0; downs = 0;
    a = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 2) a = 1'b0;
      if (step && dir) ups++;
      if (step && !dir) downs++;
    end
    n_tests++;
    if (ups !== 1 || downs !== 1 || count !== 8'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_long: got up=%0d down=%0d count=%0d err=%b, want 1 1 0 0",
               ups, downs, count, err);
    end
  endtask

  task automatic test_illegal();
    int first, ns, wa;
    logic err_at5;
    move_pins(1'b1, 1'b1, first, ns, wa);
    n_tests++;
    if (err !== 1'b1 || ns !== 0 || count !== 8'd0 || dir !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal: got err=%b nsteps=%0d count=%0d dir=%b, want 1 0 0 0", err, ns, count, dir);
    end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clr: got err=%b, want 0", err);
    end
    // Hold err_clr through a second illegal jump: set must win on that edge.
    err_clr = 1'b1;
    a = 1'b0; b = 1'b0;
    err_at5 = 1'b0; ns = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 5) err_at5 = err;
      if (step) ns++;
    end
    err_clr = 1'b0;
    n_tests++;
    if (err_at5 !== 1'b1 || err !== 1'b0 || ns !== 0 || count !== 8'd0) begin
      n_fail++;
      $display("FAIL err_set_wins: got err@5=%b err_end=%b nsteps=%0d count=%0d, want 1 0 0 0",
               err_at5, err, ns, count);
    end
  endtask

  task automatic test_load();
    int first, ns, wa;
    @(posedge clk); #1;
    a = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 4) begin load = 1'b1; din = 8'd5; end
      if (i == 5) begin
        load = 1'b0;
        n_tests++;
        if (count !== 8'd5 || step !== 1'b1 || dir !== 1'b1 || wrap !== 1'b0) begin
          n_fail++;
          $display("FAIL load_vs_step: got count=%0d step=%b dir=%b wrap=%b, want 5 1 1 0",
                   count, step, dir, wrap);
        end
      end
    end
    load = 1'b1; din = 8'd255;
    @(posedge clk); #1;
    load = 1'b0;
    n_tests++;
    if (count !== 8'd255 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL load_255: got count=%0d wrap=%b, want 255 0", count, wrap);
    end
    move_pins(1'b1, 1'b1, first, ns, wa);
    n_tests++;
    if (count !== 8'd0 || wa !== 5 || ns !== 1) begin
      n_fail++;
      $display("FAIL load_then_wrap: got count=%0d wrap_at=%0d nsteps=%0d, want 0 5 1", count, wa, ns);
    end
    move_pins(1'b0, 1'b1, first, ns, wa);
    move_pins(1'b0, 1'b0, first, ns, wa);
    n_tests++;
    if (count !== 8'd2) begin
      n_fail++;
      $display("FAIL return_home: got count=%0d, want 2", count);
    end
  endtask

  task automatic test_reset_mid();
    int ns;
    @(posedge clk); #1;
    a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    #1;
    n_tests++;
    if ({count, step, dir, wrap, err} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_async: got count=%0d step=%b dir=%b wrap=%b err=%b, want all 0",
               count, step, dir, wrap, err);
    end
    a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    ns = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (step) ns++;
    end
    n_tests++;
    if (ns !== 0 || count !== 8'd0 || dir !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_after: got nsteps=%0d count=%0d dir=%b err=%b, want 0 0 0 0",
               ns, count, dir, err);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_glitch();
    test_illegal();
    test_load();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
